// File: rtl/seven_seg_scan_core_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment
// lookup table, blank/off codes and the digit-index width.
package seven_seg_scan_core_pkg;

    // Eight digits, so a 3-bit scan index.
    localparam int unsigned DIGIT_W = 3;
    localparam int unsigned N_DIGITS = 8;

    // All cathodes high (segments and dp dark) and all anodes high (no digit on).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value.
    // Listed from F down to 0 so that HEX_SEG_TABLE[n] is the pattern for n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, // F
        7'h06, // E
        7'h21, // d
        7'h46, // C
        7'h03, // b
        7'h08, // A
        7'h10, // 9
        7'h00, // 8
        7'h78, // 7
        7'h02, // 6
        7'h12, // 5
        7'h19, // 4
        7'h30, // 3
        7'h24, // 2
        7'h79, // 1
        7'h40  // 0
    };

endpackage

// File: rtl/seven_seg_scan_core_if.sv
// Display-side signal bundle: digit data and enables in, cathode/anode drive out.
interface seven_seg_scan_core_if;
    logic [31:0] data;
    logic [7:0]  digit_en;
    logic [7:0]  dp_en;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    // Master supplies what to display; slave (the scanner) drives the pins.
    modport master (output data, digit_en, dp_en, input SEG, AN);
    modport slave  (input data, digit_en, dp_en, output SEG, AN);
endinterface

// File: rtl/seven_seg_scan_core_hex_to_seg.sv
// Purely combinational nibble to active-low seven-segment pattern decoder.
module hex_to_seg
    import seven_seg_scan_core_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; no state.
    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_core.sv
// Time-multiplexed eight-digit seven-segment scanner. A prescaler produces a
// one-cycle tick every DIV_N clocks; on each tick the anode/cathode registers
// load the decode of the current digit and the digit index advances.
module seven_seg_scan_core
    import seven_seg_scan_core_pkg::*;
#(
    parameter int unsigned DIV_N = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_core_if.slave bus
);

    localparam int unsigned CNT_W = (DIV_N > 2) ? $clog2(DIV_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

    logic [CNT_W-1:0]   presc_cnt;
    logic               tick;
    logic [DIGIT_W-1:0] digit_idx;
    logic [3:0]         cur_nibble;
    logic [6:0]         cur_pattern;
    logic [7:0]         an_next;
    logic [7:0]         seg_next;

    assign tick = (presc_cnt == CNT_LAST);

    // Prescaler: free-running 0..DIV_N-1, wraps on the tick cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + CNT_W'(1);
        end
    end

    // Digit index: advances once per tick, naturally wrapping 7 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_idx <= '0;
        end else if (tick) begin
            digit_idx <= digit_idx + DIGIT_W'(1);
        end
    end

    assign cur_nibble = bus.data[{digit_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .seg    (cur_pattern)
    );

    // Decode of the digit currently selected (before the index increments).
    always_comb begin
        an_next  = AN_OFF;
        seg_next = {~bus.dp_en[digit_idx], cur_pattern};
        if (bus.digit_en[digit_idx]) begin
            an_next = ~(8'b1 << digit_idx);
        end
    end

    // Output registers: load only on a tick so input changes between ticks
    // are invisible; reset blanks the display and wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.AN  <= AN_OFF;
            bus.SEG <= SEG_BLANK;
        end else if (tick) begin
            bus.AN  <= an_next;
            bus.SEG <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_core.sv
// Directed bench for seven_seg_scan_core with DIV_N = 4.
module tb_seven_seg_scan_core;

  localparam int unsigned DIV_N = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_core_if bus_if ();

  seven_seg_scan_core #(.DIV_N(DIV_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_an;
  logic [7:0] last_seg;
  bit         mon_on = 1'b0;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scan interval: outputs must hold for DIV_N-1 edges, then load.
  task automatic tick_and_check(input string tag, input logic [7:0] exp_an, input logic [7:0] exp_seg);
    repeat (DIV_N - 1) step();
    check_val({tag, "_hold_an"}, bus_if.AN, last_an);
    check_val({tag, "_hold_seg"}, bus_if.SEG, last_seg);
    step();
    check_val({tag, "_an"}, bus_if.AN, exp_an);
    check_val({tag, "_seg"}, bus_if.SEG, exp_seg);
    last_an  = exp_an;
    last_seg = exp_seg;
  endtask

  // Drain queued {AN,SEG} pairs, one tick each.
  task automatic run_queue(input string tag);
    logic [7:0] a;
    logic [7:0] s;
    while (exp_q.size() >= 2) begin
      a = exp_q.pop_front();
      s = exp_q.pop_front();
      tick_and_check(tag, a, s);
    end
  endtask

  // At most one anode may be low at any time.
  always @(negedge clk) begin
    if (mon_on) begin
      check_val("an_onehot", 8'($countones(~bus_if.AN) <= 1), 8'd1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst             = 1'b1;
    bus_if.data     = 32'h76543210;
    bus_if.digit_en = 8'hFF;
    bus_if.dp_en    = 8'h00;

    // Reset held three cycles.
    repeat (3) step();
    check_val("rst_an", bus_if.AN, 8'hFF);
    check_val("rst_seg", bus_if.SEG, 8'hFF);
    last_an  = 8'hFF;
    last_seg = 8'hFF;
    rst      = 1'b0;
    mon_on   = 1'b1;

    // First tick DIV_N cycles after release, then a full scan and wrap.
    exp_q = '{8'hFE, 8'hC0, 8'hFD, 8'hF9, 8'hFB, 8'hA4, 8'hF7, 8'hB0,
              8'hEF, 8'h99, 8'hDF, 8'h92, 8'hBF, 8'h82, 8'h7F, 8'hF8,
              8'hFE, 8'hC0};
    run_queue("scan1");

    // New data one cycle after a tick: must not show until the next tick.
    step();
    bus_if.data = 32'hFEDCBA98;
    step();
    check_val("mid_hold_an", bus_if.AN, 8'hFE);
    check_val("mid_hold_seg", bus_if.SEG, 8'hC0);
    repeat (DIV_N - 3) step();
    step();
    check_val("d1_an", bus_if.AN, 8'hFD);
    check_val("d1_seg", bus_if.SEG, 8'h90);
    last_an  = 8'hFD;
    last_seg = 8'h90;
    exp_q = '{8'hFB, 8'h88, 8'hF7, 8'h83, 8'hEF, 8'hC6, 8'hDF, 8'hA1,
              8'hBF, 8'h86, 8'h7F, 8'h8E, 8'hFE, 8'h80};
    run_queue("scan2");

    // Partial enables and decimal point on digit 0 only.
    bus_if.digit_en = 8'h0F;
    bus_if.dp_en    = 8'h01;
    exp_q = '{8'hFD, 8'h90, 8'hFB, 8'h88, 8'hF7, 8'h83, 8'hFF, 8'hC6,
              8'hFF, 8'hA1, 8'hFF, 8'h86, 8'hFF, 8'h8E, 8'hFE, 8'h00};
    run_queue("scan3");

    // Reset in the middle of digit 5.
    bus_if.data     = 32'h76543210;
    bus_if.digit_en = 8'hFF;
    bus_if.dp_en    = 8'h00;
    exp_q = '{8'hFD, 8'hF9, 8'hFB, 8'hA4, 8'hF7, 8'hB0, 8'hEF, 8'h99,
              8'hDF, 8'h92};
    run_queue("scan4");
    step();
    rst = 1'b1;
    step();
    check_val("midrst_an", bus_if.AN, 8'hFF);
    check_val("midrst_seg", bus_if.SEG, 8'hFF);
    rst      = 1'b0;
    last_an  = 8'hFF;
    last_seg = 8'hFF;
    tick_and_check("restart0", 8'hFE, 8'hC0);
    tick_and_check("restart1", 8'hFD, 8'hF9);

    // Reset landing on the would-be tick edge must win.
    repeat (DIV_N - 1) step();
    rst = 1'b1;
    step();
    check_val("coinrst_an", bus_if.AN, 8'hFF);
    check_val("coinrst_seg", bus_if.SEG, 8'hFF);
    rst      = 1'b0;
    last_an  = 8'hFF;
    last_seg = 8'hFF;
    tick_and_check("restart_b", 8'hFE, 8'hC0);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
